// File: rtl/flash_page_prog_sequencer_if.sv
// Signal bundle between the page-program sequencer, its job controller,
// the receive FIFO read port and the spi_phy load/fetch port.
interface flash_page_prog_sequencer_if;
    logic        start;
    logic [31:0] start_addr;
    logic [15:0] page_count;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] pages_done;
    logic        buff_prog_empty;
    logic        buff_rden;
    logic [63:0] buff_data;
    logic        load_out;
    logic        load_full_in;
    logic [7:0]  command_len_out;
    logic [7:0]  addr_len_out;
    logic [7:0]  dummy_len_out;
    logic [15:0] data_len_out;
    logic [31:0] command_out;
    logic [63:0] addr_out;
    logic [63:0] data_out;
    logic        tristate_out;
    logic        spi_busy_in;
    logic [63:0] fetch_din;
    logic        fetch_out;
    logic        fetch_empty_in;

    modport master (
        input  start, start_addr, page_count, buff_prog_empty, buff_data,
               load_full_in, spi_busy_in, fetch_din, fetch_empty_in,
        output busy, done, error, pages_done, buff_rden, load_out,
               command_len_out, addr_len_out, dummy_len_out, data_len_out,
               command_out, addr_out, data_out, tristate_out, fetch_out
    );

    modport slave (
        output start, start_addr, page_count, buff_prog_empty, buff_data,
               load_full_in, spi_busy_in, fetch_din, fetch_empty_in,
        input  busy, done, error, pages_done, buff_rden, load_out,
               command_len_out, addr_len_out, dummy_len_out, data_len_out,
               command_out, addr_out, data_out, tristate_out, fetch_out
    );
endinterface

// File: rtl/flash_page_prog_sequencer.sv
// Multi-page QSPI programming sequencer: WREN, 4-byte Page Program fed from
// the receive FIFO, then RDSR polling until WIP clears, once per 256-byte page.
module flash_page_prog_sequencer #(
    parameter int unsigned PAGE_WORDS = 32,
    parameter int unsigned POLL_LIMIT = 20000,
    parameter logic [7:0]  CMD_WREN   = 8'h06,
    parameter logic [7:0]  CMD_PP     = 8'h12,
    parameter logic [7:0]  CMD_RDSR   = 8'h05
) (
    input logic                         clk_i,
    input logic                         rst_ni,
    flash_page_prog_sequencer_if.master bus
);
    localparam int WCW = $clog2(PAGE_WORDS + 1);
    localparam int PCW = $clog2(POLL_LIMIT + 1);
    localparam logic [15:0] PAGE_BITS = 16'(PAGE_WORDS * 64);

    typedef enum logic [3:0] {
        IDLE, WAIT_DATA, WREN, WAIT_IDLE, PP_HDR, PP_DATA, RDSR, FETCH, CHECK, NEXT
    } state_e;

    typedef enum logic [1:0] {PH_PREP, PH_CAP, PH_LOAD} phase_e;

    state_e           state_q, state_d, ret_q, ret_d;
    phase_e           phase_q, phase_d;
    logic [1:0]       wait_q, wait_d;
    logic [WCW-1:0]   word_q, word_d;
    logic [PCW-1:0]   poll_q, poll_d;
    logic             wip_q, wip_d;
    logic [31:0]      addr_q, addr_d;
    logic [15:0]      count_q, count_d, pages_q, pages_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [7:0]       cmdLen_q, cmdLen_d, addrLen_q, addrLen_d, opcode_q, opcode_d;
    logic [15:0]      dataLen_q, dataLen_d;
    logic             tristate_q, tristate_d;
    logic [63:0]      data_q, data_d;
    logic             loadReq, loadFire, unusedFetch;

    // Strobes are decoded combinationally so load_out can never coincide with load_full_in.
    assign loadReq  = (state_q == WREN || state_q == PP_HDR || state_q == PP_DATA ||
                       state_q == RDSR) && (phase_q == PH_LOAD);
    assign loadFire = loadReq & ~bus.load_full_in;

    assign bus.load_out        = loadFire;
    assign bus.buff_rden       = (state_q == PP_HDR || state_q == PP_DATA) && (phase_q == PH_PREP);
    assign bus.fetch_out       = (state_q == FETCH) && !bus.fetch_empty_in;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.error           = error_q;
    assign bus.pages_done      = pages_q;
    assign bus.command_len_out = cmdLen_q;
    assign bus.addr_len_out    = addrLen_q;
    assign bus.dummy_len_out   = 8'd0;
    assign bus.data_len_out    = dataLen_q;
    assign bus.command_out     = {24'd0, opcode_q};
    assign bus.addr_out        = {32'd0, addr_q};
    assign bus.data_out        = data_q;
    assign bus.tristate_out    = tristate_q;
    assign unusedFetch         = ^bus.fetch_din[63:1];

    always_comb begin
        state_d = state_q;  ret_d = ret_q;  phase_d = phase_q;  wait_d = wait_q;
        word_d = word_q;  poll_d = poll_q;  wip_d = wip_q;  addr_d = addr_q;
        count_d = count_q;  pages_d = pages_q;  busy_d = busy_q;
        done_d = 1'b0;  error_d = 1'b0;
        cmdLen_d = cmdLen_q;  addrLen_d = addrLen_q;  opcode_d = opcode_q;
        dataLen_d = dataLen_q;  tristate_d = tristate_q;  data_d = data_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start && !busy_q) begin
                    busy_d  = 1'b1;
                    addr_d  = bus.start_addr;
                    count_d = bus.page_count;
                    pages_d = '0;
                    poll_d  = '0;
                    if (bus.page_count == 16'd0) done_d = 1'b1;
                    else                         state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (!bus.buff_prog_empty) begin
                    state_d = WREN;
                    phase_d = PH_PREP;
                    word_d  = '0;
                end
            end
            WREN: begin
                if (phase_q == PH_PREP) begin
                    cmdLen_d = 8'd8;  addrLen_d = 8'd0;  dataLen_d = 16'd0;
                    tristate_d = 1'b0;  opcode_d = CMD_WREN;
                    phase_d = PH_LOAD;
                end else if (loadFire) begin
                    state_d = WAIT_IDLE;  ret_d = PP_HDR;  wait_d = '0;  phase_d = PH_PREP;
                end
            end
            PP_HDR, PP_DATA: begin
                // Continuation words keep the header fields; the phy only looks at data.
                case (phase_q)
                    PH_PREP: phase_d = PH_CAP;
                    PH_CAP: begin
                        data_d = bus.buff_data;
                        if (state_q == PP_HDR) begin
                            cmdLen_d = 8'd8;  addrLen_d = 8'd32;  dataLen_d = PAGE_BITS;
                            tristate_d = 1'b0;  opcode_d = CMD_PP;
                        end
                        phase_d = PH_LOAD;
                    end
                    default: begin
                        if (loadFire) begin
                            word_d  = word_q + 1'b1;
                            phase_d = PH_PREP;
                            if (word_q + 1'b1 == WCW'(PAGE_WORDS)) begin
                                state_d = WAIT_IDLE;  ret_d = RDSR;  wait_d = '0;
                            end else begin
                                state_d = PP_DATA;
                            end
                        end
                    end
                endcase
            end
            RDSR: begin
                if (phase_q == PH_PREP) begin
                    cmdLen_d = 8'd8;  addrLen_d = 8'd0;  dataLen_d = 16'd8;
                    tristate_d = 1'b1;  opcode_d = CMD_RDSR;
                    phase_d = PH_LOAD;
                end else if (loadFire) begin
                    state_d = WAIT_IDLE;  ret_d = FETCH;  wait_d = '0;  phase_d = PH_PREP;
                end
            end
            WAIT_IDLE: begin
                // Give the phy two cycles to raise spi_busy_in before trusting it.
                if (wait_q != 2'd2)        wait_d  = wait_q + 2'd1;
                else if (!bus.spi_busy_in) state_d = ret_q;
            end
            FETCH: begin
                if (!bus.fetch_empty_in) begin
                    wip_d   = bus.fetch_din[0];
                    poll_d  = poll_q + 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!wip_q) begin
                    state_d = NEXT;
                end else if (poll_q >= PCW'(POLL_LIMIT)) begin
                    error_d = 1'b1;  busy_d = 1'b0;  state_d = IDLE;
                end else begin
                    state_d = RDSR;  phase_d = PH_PREP;
                end
            end
            NEXT: begin
                pages_d = pages_q + 16'd1;
                addr_d  = addr_q + 32'd256;
                poll_d  = '0;
                if (pages_q + 16'd1 == count_q) begin
                    done_d = 1'b1;  busy_d = 1'b0;  state_d = IDLE;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;  ret_q <= IDLE;  phase_q <= PH_PREP;  wait_q <= '0;
            word_q <= '0;  poll_q <= '0;  wip_q <= 1'b0;  addr_q <= '0;
            count_q <= '0;  pages_q <= '0;  busy_q <= 1'b0;  done_q <= 1'b0;  error_q <= 1'b0;
            cmdLen_q <= '0;  addrLen_q <= '0;  opcode_q <= '0;  dataLen_q <= '0;
            tristate_q <= 1'b0;  data_q <= '0;
        end else begin
            state_q <= state_d;  ret_q <= ret_d;  phase_q <= phase_d;  wait_q <= wait_d;
            word_q <= word_d;  poll_q <= poll_d;  wip_q <= wip_d;  addr_q <= addr_d;
            count_q <= count_d;  pages_q <= pages_d;  busy_q <= busy_d;  done_q <= done_d;
            error_q <= error_d;  cmdLen_q <= cmdLen_d;  addrLen_q <= addrLen_d;
            opcode_q <= opcode_d;  dataLen_q <= dataLen_d;  tristate_q <= tristate_d;
            data_q <= data_d;
        end
    end
endmodule

// File: tb/tb_flash_page_prog_sequencer.sv
// Directed bench for flash_page_prog_sequencer with a FIFO model and a small
// spi_phy model that answers RDSR loads from a per-test status list.
module tb_flash_page_prog_sequencer;
    localparam int PAGE_WORDS = 32;
    localparam int POLL_LIMIT = 4;

    logic clk;
    logic rstN;
    int   assertCount = 0;
    int   failCount   = 0;

    flash_page_prog_sequencer_if bus();

    flash_page_prog_sequencer #(
        .PAGE_WORDS(PAGE_WORDS), .POLL_LIMIT(POLL_LIMIT),
        .CMD_WREN(8'h06), .CMD_PP(8'h12), .CMD_RDSR(8'h05)
    ) dut (
        .clk_i(clk), .rst_ni(rstN), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model: words requested by the tasks are appended through a req/ack handshake.
    logic [63:0] fifoQ[$];
    int          pushReq = 0, pushAck = 0, pushNum = 0, rdCount = 0;
    logic [63:0] pushBase = '0;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fifoQ.delete();
            bus.buff_data       <= '0;
            bus.buff_prog_empty <= 1'b1;
            pushAck             <= pushReq;
        end else begin
            if (bus.buff_rden) begin
                if (fifoQ.size() > 0) bus.buff_data <= fifoQ.pop_front();
                rdCount <= rdCount + 1;
            end
            if (pushAck != pushReq) begin
                for (int i = 0; i < pushNum; i++) fifoQ.push_back(pushBase + 64'(i));
                pushAck <= pushReq;
            end
            bus.buff_prog_empty <= (fifoQ.size() < PAGE_WORDS);
        end
    end

    // Phy model: logs every load, stays busy a few cycles, answers RDSR with a status byte.
    logic [7:0]  statusList [0:3];
    int          statusLen = 1, rdsrBase = 0, rdsrCount = 0, loadCount = 0, fullViolations = 0;
    int          busyCnt;
    logic        statusPending, expectHdr;
    logic [7:0]  statusVal;
    logic [7:0]  cmdLog[$];
    logic [31:0] hdrAddr[$];
    logic [15:0] hdrLen[$];
    logic [63:0] ppData[$];

    function automatic logic [7:0] pickStatus(input int k);
        if (k < statusLen) return statusList[k];
        return statusList[statusLen-1];
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            busyCnt <= 0;  statusPending <= 1'b0;  expectHdr <= 1'b0;  statusVal <= '0;
            bus.spi_busy_in <= 1'b0;  bus.fetch_empty_in <= 1'b1;  bus.fetch_din <= '0;
        end else begin
            if (bus.fetch_out) bus.fetch_empty_in <= 1'b1;
            if (bus.load_out) begin
                loadCount <= loadCount + 1;
                if (bus.load_full_in) fullViolations <= fullViolations + 1;
                cmdLog.push_back(bus.command_out[7:0]);
                busyCnt <= 3;
                bus.spi_busy_in <= 1'b1;
                case (bus.command_out[7:0])
                    8'h06: expectHdr <= 1'b1;
                    8'h12: begin
                        ppData.push_back(bus.data_out);
                        if (expectHdr) begin
                            hdrAddr.push_back(bus.addr_out[31:0]);
                            hdrLen.push_back(bus.data_len_out);
                            expectHdr <= 1'b0;
                        end
                    end
                    8'h05: begin
                        statusVal     <= pickStatus(rdsrCount - rdsrBase);
                        statusPending <= 1'b1;
                        rdsrCount     <= rdsrCount + 1;
                    end
                    default: ;
                endcase
            end else if (busyCnt > 0) begin
                busyCnt <= busyCnt - 1;
                if (busyCnt == 1) begin
                    bus.spi_busy_in <= 1'b0;
                    if (statusPending) begin
                        bus.fetch_empty_in <= 1'b0;
                        bus.fetch_din      <= {56'd0, statusVal};
                        statusPending      <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] count);
        @(negedge clk);
        bus.start = 1'b1;  bus.start_addr = addr;  bus.page_count = count;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic preload(input logic [63:0] base, input int n);
        pushBase = base;  pushNum = n;  pushReq = pushReq + 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic setStatus(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input int len);
        statusList[0] = s0;  statusList[1] = s1;  statusList[2] = s2;  statusList[3] = s2;
        statusLen = len;
        rdsrBase  = rdsrCount;
    endtask

    task automatic waitDone(input int maxCycles, output bit gotDone, output bit gotError);
        gotDone = 1'b0;  gotError = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (bus.done)  begin gotDone  = 1'b1; break; end
            if (bus.error) begin gotError = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        assertCount++;
        if ({bus.busy, bus.done, bus.error, bus.buff_rden, bus.load_out, bus.fetch_out, bus.tristate_out} !== 7'd0) begin
            failCount++;
            $display("[TB] FAIL reset_strobes: got %b expected 0", {bus.busy, bus.done, bus.error, bus.buff_rden, bus.load_out, bus.fetch_out, bus.tristate_out});
        end
        assertCount++;
        if (bus.pages_done !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL reset_pages_done: got %0d expected 0", bus.pages_done);
        end
        assertCount++;
        if ({bus.command_out, bus.addr_out, bus.data_out, bus.data_len_out, bus.command_len_out, bus.addr_len_out, bus.dummy_len_out} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_fields: got %0h expected 0", {bus.command_out, bus.addr_out, bus.data_out});
        end
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic runPage(input string name, input logic [31:0] addr, input logic [63:0] base,
                           input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                           input int len, input int expRdsr);
        int cmdSnap, hdrSnap, ppSnap, rdsrSnap, rdSnap, errs;
        bit gotDone, gotError;
        logic [31:0] a;
        logic [15:0] l;
        logic [7:0] c0, c1;
        setStatus(s0, s1, s2, len);
        preload(base, PAGE_WORDS);
        cmdSnap = cmdLog.size();  hdrSnap = hdrAddr.size();  ppSnap = ppData.size();
        rdsrSnap = rdsrCount;  rdSnap = rdCount;
        applyStimulus(addr, 16'd1);
        waitDone(3000, gotDone, gotError);
        assertCount++;
        if (gotDone !== 1'b1 || gotError !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL %s_done: got done=%0d error=%0d expected done=1 error=0", name, gotDone, gotError);
        end
        assertCount++;
        if (bus.pages_done !== 16'd1 || bus.busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL %s_pages: got pages=%0d busy=%0d expected pages=1 busy=0", name, bus.pages_done, bus.busy);
        end
        c0 = (cmdLog.size() > cmdSnap)     ? cmdLog[cmdSnap]     : 8'hxx;
        c1 = (cmdLog.size() > cmdSnap + 1) ? cmdLog[cmdSnap + 1] : 8'hxx;
        assertCount++;
        if (c0 !== 8'h06 || c1 !== 8'h12) begin
            failCount++;
            $display("[TB] FAIL %s_order: got %0h,%0h expected 06,12", name, c0, c1);
        end
        a = (hdrAddr.size() > hdrSnap) ? hdrAddr[hdrSnap] : 32'hxxxxxxxx;
        l = (hdrLen.size() > hdrSnap)  ? hdrLen[hdrSnap]  : 16'hxxxx;
        assertCount++;
        if (a !== addr || l !== 16'd2048) begin
            failCount++;
            $display("[TB] FAIL %s_header: got addr=%0h len=%0d expected addr=%0h len=2048", name, a, l, addr);
        end
        assertCount++;
        if (ppData.size() - ppSnap !== PAGE_WORDS || rdCount - rdSnap !== PAGE_WORDS) begin
            failCount++;
            $display("[TB] FAIL %s_words: got pp=%0d reads=%0d expected 32", name, ppData.size() - ppSnap, rdCount - rdSnap);
        end
        errs = 0;
        for (int i = 0; i < PAGE_WORDS; i++)
            if (ppSnap + i >= ppData.size() || ppData[ppSnap + i] !== base + 64'(i)) errs++;
        assertCount++;
        if (errs !== 0) begin
            failCount++;
            $display("[TB] FAIL %s_data_order: got %0d bad words expected 0", name, errs);
        end
        assertCount++;
        if (rdsrCount - rdsrSnap !== expRdsr || fifoQ.size() !== 0) begin
            failCount++;
            $display("[TB] FAIL %s_rdsr: got rdsr=%0d fifo=%0d expected rdsr=%0d fifo=0", name, rdsrCount - rdsrSnap, fifoQ.size(), expRdsr);
        end
        @(negedge clk);
        assertCount++;
        if (bus.done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL %s_done_pulse: got %0d expected 0", name, bus.done);
        end
    endtask

    task automatic test_single_page();
        runPage("single", 32'h0000_1000, 64'hA5A5_0000_0000_0000, 8'h03, 8'h03, 8'h00, 3, 3);
    endtask

    task automatic test_zero_pages();
        int loadSnap;
        loadSnap = loadCount;
        applyStimulus(32'h0000_5000, 16'd0);
        assertCount++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL zero_first: got done=%0d busy=%0d expected 1,1", bus.done, bus.busy);
        end
        @(negedge clk);
        assertCount++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pages_done !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL zero_second: got done=%0d busy=%0d pages=%0d expected 0,0,0", bus.done, bus.busy, bus.pages_done);
        end
        repeat (5) @(negedge clk);
        assertCount++;
        if (loadCount - loadSnap !== 0) begin
            failCount++;
            $display("[TB] FAIL zero_loads: got %0d expected 0", loadCount - loadSnap);
        end
    endtask

    task automatic test_addr_wrap();
        int hdrSnap, ppSnap;
        bit gotDone, gotError;
        logic [31:0] exp [0:2];
        logic [31:0] a;
        exp[0] = 32'hFFFF_FF00;  exp[1] = 32'h0000_0000;  exp[2] = 32'h0000_0100;
        setStatus(8'h00, 8'h00, 8'h00, 1);
        preload(64'hB000_0000_0000_0000, 3 * PAGE_WORDS);
        hdrSnap = hdrAddr.size();  ppSnap = ppData.size();
        applyStimulus(32'hFFFF_FF00, 16'd3);
        waitDone(6000, gotDone, gotError);
        assertCount++;
        if (gotDone !== 1'b1 || bus.pages_done !== 16'd3) begin
            failCount++;
            $display("[TB] FAIL wrap_done: got done=%0d pages=%0d expected 1,3", gotDone, bus.pages_done);
        end
        for (int p = 0; p < 3; p++) begin
            a = (hdrAddr.size() > hdrSnap + p) ? hdrAddr[hdrSnap + p] : 32'hxxxxxxxx;
            assertCount++;
            if (a !== exp[p]) begin
                failCount++;
                $display("[TB] FAIL wrap_addr%0d: got %0h expected %0h", p, a, exp[p]);
            end
        end
        assertCount++;
        if (ppData.size() - ppSnap !== 3 * PAGE_WORDS) begin
            failCount++;
            $display("[TB] FAIL wrap_words: got %0d expected 96", ppData.size() - ppSnap);
        end
    endtask

    task automatic test_load_full();
        int ppSnap, ppHold, violSnap, badLoads, errs;
        bit gotDone, gotError, reached;
        logic [63:0] base;
        base = 64'hC000_0000_0000_0000;
        setStatus(8'h00, 8'h00, 8'h00, 1);
        preload(base, PAGE_WORDS);
        ppSnap = ppData.size();  violSnap = fullViolations;  reached = 1'b0;  badLoads = 0;
        applyStimulus(32'h0000_2000, 16'd1);
        for (int i = 0; i < 500; i++) begin
            if (ppData.size() - ppSnap >= 5) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        assertCount++;
        if (reached !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL full_reach: got %0d words expected 5", ppData.size() - ppSnap);
        end
        bus.load_full_in = 1'b1;
        ppHold = ppData.size();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.load_out) badLoads++;
            @(negedge clk);
        end
        assertCount++;
        if (badLoads !== 0 || ppData.size() !== ppHold) begin
            failCount++;
            $display("[TB] FAIL full_hold: got loads=%0d words=%0d expected 0,%0d", badLoads, ppData.size(), ppHold);
        end
        bus.load_full_in = 1'b0;
        waitDone(3000, gotDone, gotError);
        errs = 0;
        for (int i = 0; i < PAGE_WORDS; i++)
            if (ppSnap + i >= ppData.size() || ppData[ppSnap + i] !== base + 64'(i)) errs++;
        assertCount++;
        if (gotDone !== 1'b1 || errs !== 0 || ppData.size() - ppSnap !== PAGE_WORDS || fullViolations !== violSnap) begin
            failCount++;
            $display("[TB] FAIL full_data: got done=%0d bad=%0d words=%0d expected 1,0,32", gotDone, errs, ppData.size() - ppSnap);
        end
    endtask

    task automatic test_poll_timeout();
        int rdsrSnap;
        bit gotDone, gotError;
        setStatus(8'h01, 8'h01, 8'h01, 1);
        preload(64'hD000_0000_0000_0000, PAGE_WORDS);
        rdsrSnap = rdsrCount;
        applyStimulus(32'h0000_3000, 16'd1);
        waitDone(3000, gotDone, gotError);
        assertCount++;
        if (gotError !== 1'b1 || gotDone !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL timeout_error: got error=%0d done=%0d expected 1,0", gotError, gotDone);
        end
        assertCount++;
        if (rdsrCount - rdsrSnap !== POLL_LIMIT) begin
            failCount++;
            $display("[TB] FAIL timeout_polls: got %0d expected %0d", rdsrCount - rdsrSnap, POLL_LIMIT);
        end
        assertCount++;
        if (bus.busy !== 1'b0 || bus.pages_done !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL timeout_state: got busy=%0d pages=%0d expected 0,0", bus.busy, bus.pages_done);
        end
        @(negedge clk);
        assertCount++;
        if (bus.error !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL timeout_pulse: got %0d expected 0", bus.error);
        end
    endtask

    task automatic test_reset_mid();
        int ppSnap;
        bit reached, sawPulse;
        setStatus(8'h00, 8'h00, 8'h00, 1);
        preload(64'hE000_0000_0000_0000, PAGE_WORDS);
        ppSnap = ppData.size();  reached = 1'b0;  sawPulse = 1'b0;
        applyStimulus(32'h0000_4000, 16'd1);
        for (int i = 0; i < 500; i++) begin
            if (ppData.size() - ppSnap >= 10) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        assertCount++;
        if (reached !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midrst_reach: got %0d words expected 10", ppData.size() - ppSnap);
        end
        rstN = 1'b0;
        #1;
        assertCount++;
        if ({bus.busy, bus.done, bus.error, bus.load_out, bus.buff_rden, bus.fetch_out, bus.pages_done, bus.command_out, bus.data_out} !== '0) begin
            failCount++;
            $display("[TB] FAIL midrst_outputs: got busy=%0d load=%0d rden=%0d cmd=%0h data=%0h expected 0", bus.busy, bus.load_out, bus.buff_rden, bus.command_out, bus.data_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done || bus.error) sawPulse = 1'b1;
        end
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done || bus.error) sawPulse = 1'b1;
        end
        assertCount++;
        if (sawPulse !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midrst_pulse: got %0d expected 0", sawPulse);
        end
        runPage("after_reset", 32'h0000_4000, 64'hF000_0000_0000_0000, 8'h00, 8'h00, 8'h00, 1, 1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstN = 1'b0;
        bus.start = 1'b0;  bus.start_addr = '0;  bus.page_count = '0;  bus.load_full_in = 1'b0;
        $display("[TB] starting flash_page_prog_sequencer bench");
        test_reset();
        test_single_page();
        test_zero_pages();
        test_addr_wrap();
        test_load_full();
        test_poll_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
